// File: rtl/adsr_if.sv
// adsr_if: envelope stage signal bundle.
// master drives note/sample/rates, slave returns enveloped outputs.
interface adsr_if;
  logic        gate;
  logic [15:0] sample_in;
  logic [15:0] attack_rate;
  logic [15:0] decay_rate;
  logic [15:0] sustain_level;
  logic [15:0] release_rate;
  logic [15:0] sample_out;
  logic [15:0] env_level;
  logic [2:0]  state;
  logic        active;

  modport master (
    output gate, sample_in,
    output attack_rate, decay_rate,
    output sustain_level, release_rate,
    input  sample_out, env_level,
    input  state, active
  );

  modport slave (
    input  gate, sample_in,
    input  attack_rate, decay_rate,
    input  sustain_level, release_rate,
    output sample_out, env_level,
    output state, active
  );
endinterface

// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR amplitude envelope applied to a signed sample.
// Optional macro ADSR_HARD_RETRIG_EN: rise in RELEASE restarts from 0.
module adsr_envelope #(
  parameter int TICK_DIV = 1000,
  parameter int TICK_W   = 10
) (
  input  logic   clk,
  input  logic   rst_n,
  adsr_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic [15:0]         env_q, env_d;
  logic [15:0]         out_q, out_d;
  logic                gate_q;
  logic                tick, rise, fall;
  logic [15:0]         att, dec, rel;
  logic [16:0]         att_sum, dec_dif, rel_dif;
  logic signed [32:0]  prod;
  logic                unused_prod;

  // Prescaler: wraps after TICK_DIV clocks, tick on last count.
  always_comb begin
    tick  = (cnt_q == TICK_W'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Edge detect and zero-rate substitution.
  always_comb begin
    rise = bus.gate & ~gate_q;
    fall = ~bus.gate & gate_q;
    att  = (bus.attack_rate  == '0) ? 16'd1 : bus.attack_rate;
    dec  = (bus.decay_rate   == '0) ? 16'd1 : bus.decay_rate;
    rel  = (bus.release_rate == '0) ? 16'd1 : bus.release_rate;
    att_sum = {1'b0, env_q} + {1'b0, att};
    dec_dif = {1'b0, env_q} - {1'b0, dec};
    rel_dif = {1'b0, env_q} - {1'b0, rel};
  end

  // Next state and envelope level; edges beat ticks.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    unique case (state_q)
      S_IDLE: begin
        env_d = '0;
        if (rise) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (fall) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          if (att_sum >= 17'h0FFFF) begin
            env_d   = 16'hFFFF;
            state_d = S_DECAY;
          end else begin
            env_d = att_sum[15:0];
          end
        end
      end
      S_DECAY: begin
        if (fall) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          if (dec_dif[16] ||
              dec_dif[15:0] <= bus.sustain_level) begin
            env_d   = bus.sustain_level;
            state_d = S_SUSTAIN;
          end else begin
            env_d = dec_dif[15:0];
          end
        end
      end
      S_SUSTAIN: begin
        env_d = bus.sustain_level;
        if (fall) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (rise) begin
          state_d = S_ATTACK;
`ifdef ADSR_HARD_RETRIG_EN
          env_d   = '0;
`else
          env_d   = env_q;
`endif
        end else if (tick) begin
          if (rel_dif[16] || rel_dif[15:0] == '0) begin
            env_d   = '0;
            state_d = S_IDLE;
          end else begin
            env_d = rel_dif[15:0];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        env_d   = '0;
      end
    endcase
  end

  // Scale sample by current level; floor shift by 16.
  always_comb begin
    prod  = $signed(bus.sample_in) * $signed({1'b0, env_q});
    out_d = prod[31:16];
  end

  assign unused_prod = ^{prod[32], prod[15:0]};

  // State, level, prescaler, gate and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      env_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      gate_q  <= bus.gate;
    end
  end

  assign bus.sample_out = out_q;
  assign bus.env_level  = env_q;
  assign bus.state      = state_q;
  assign bus.active     = (state_q != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed ADSR scenarios against a level model.
// Builds with or without ADSR_HARD_RETRIG_EN.
module tb_adsr_envelope;
  localparam int TD = 4;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  adsr_if bus ();

  adsr_envelope #(.TICK_DIV(TD), .TICK_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     m_cnt, m_state, m_env, m_out;
  bit     m_gq, m_tick, m_rise, m_fall;
  longint m_prod;

  function automatic int eff(logic [15:0] r);
    return (r == 16'd0) ? 1 : int'(r);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: envelope rules in plain integer arithmetic.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_state = 0; m_env = 0; m_out = 0; m_gq = 0;
    end else begin
      m_tick = (m_cnt == TD - 1);
      m_cnt  = m_tick ? 0 : m_cnt + 1;
      m_rise = bus.gate && !m_gq;
      m_fall = !bus.gate && m_gq;
      m_gq   = bus.gate;
      m_prod = longint'($signed(bus.sample_in)) * longint'(m_env);
      m_out  = int'((m_prod >>> 16) & 64'hFFFF);
      if ((m_state == 0 || m_state == 4) && m_rise) begin
`ifdef ADSR_HARD_RETRIG_EN
        if (m_state == 4) m_env = 0;
`endif
        m_state = 1;
      end else if (m_state >= 1 && m_state <= 3 && m_fall) begin
        if (m_state == 3) m_env = int'(bus.sustain_level);
        m_state = 4;
      end else begin
        case (m_state)
          0: m_env = 0;
          1: if (m_tick) begin
               m_env = m_env + eff(bus.attack_rate);
               if (m_env >= 65535) begin
                 m_env = 65535; m_state = 2;
               end
             end
          2: if (m_tick) begin
               if (m_env - eff(bus.decay_rate)
                   <= int'(bus.sustain_level)) begin
                 m_env = int'(bus.sustain_level); m_state = 3;
               end else begin
                 m_env = m_env - eff(bus.decay_rate);
               end
             end
          3: m_env = int'(bus.sustain_level);
          default: if (m_tick) begin
               m_env = m_env - eff(bus.release_rate);
               if (m_env <= 0) begin
                 m_env = 0; m_state = 0;
               end
             end
        endcase
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_env", int'(bus.env_level), m_env);
      chk("m_state", int'(bus.state), m_state);
      chk("m_active", int'(bus.active), int'(m_state != 0));
      chk("m_out", int'(bus.sample_out), m_out);
    end
  end

  task automatic wait_env(string nm, int exp);
    logic [15:0] base;
    bit          seen;
    base = bus.env_level;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (bus.env_level != base) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout got %h expected %h",
               nm, bus.env_level, exp);
    end else begin
      chk(nm, int'(bus.env_level), exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.gate = 1'b0;
    bus.sample_in = 16'h0000;
    bus.attack_rate = 16'h4000;
    bus.decay_rate = 16'h1000;
    bus.sustain_level = 16'hC000;
    bus.release_rate = 16'h8000;
    repeat (3) @(negedge clk);
    chk("rst_env", int'(bus.env_level), 0);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_out", int'(bus.sample_out), 0);
    chk("rst_active", int'(bus.active), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_state", int'(bus.state), 0);

    bus.gate = 1'b1;
    @(negedge clk);
    chk("att_state", int'(bus.state), 1);
    wait_env("att1", 16'h4000);
    wait_env("att2", 16'h8000);
    bus.sample_in = 16'h4000;
    @(negedge clk);
    chk("scale_half", int'(bus.sample_out), 16'h2000);
    wait_env("att3", 16'hC000);
    wait_env("att4", 16'hFFFF);
    chk("decay_state", int'(bus.state), 2);
    bus.sample_in = 16'h8000;
    @(negedge clk);
    chk("scale_full", int'(bus.sample_out), 16'h8000);

    wait_env("dec1", 16'hEFFF);
    wait_env("dec2", 16'hDFFF);
    wait_env("dec3", 16'hCFFF);
    wait_env("dec4", 16'hC000);
    chk("sus_state", int'(bus.state), 3);
    bus.sustain_level = 16'hA000;
    @(negedge clk);
    chk("sus_edit", int'(bus.env_level), 16'hA000);
    bus.sustain_level = 16'hC000;
    @(negedge clk);
    chk("sus_back", int'(bus.env_level), 16'hC000);

    bus.gate = 1'b0;
    @(negedge clk);
    chk("rel_state", int'(bus.state), 4);
    wait_env("rel1", 16'h4000);
    wait_env("rel2", 16'h0000);
    chk("rel_idle", int'(bus.state), 0);
    chk("rel_active", int'(bus.active), 0);
    bus.sample_in = 16'h7FFF;
    @(negedge clk);
    chk("scale_zero", int'(bus.sample_out), 0);

    bus.release_rate = 16'h4000;
    bus.gate = 1'b1;
    wait_env("ret_a1", 16'h4000);
    wait_env("ret_a2", 16'h8000);
    bus.gate = 1'b0;
    @(negedge clk);
    chk("ret_rel", int'(bus.state), 4);
    wait_env("ret_r1", 16'h4000);
    bus.gate = 1'b1;
    @(negedge clk);
    chk("ret_state", int'(bus.state), 1);
`ifdef ADSR_HARD_RETRIG_EN
    chk("ret_clear", int'(bus.env_level), 0);
    wait_env("ret_up", 16'h4000);
    wait_env("ret_up2", 16'h8000);
`else
    chk("ret_hold", int'(bus.env_level), 16'h4000);
    wait_env("ret_up", 16'h8000);
`endif

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_env", int'(bus.env_level), 0);
    chk("arst_state", int'(bus.state), 0);
    chk("arst_out", int'(bus.sample_out), 0);
    chk("arst_active", int'(bus.active), 0);
    bus.gate = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_state", int'(bus.state), 0);
    chk("post_active", int'(bus.active), 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
